// File: rtl/wbu_pkg.sv
// Shared write-back definitions: grant-source encodings and arbiter defaults.
package wbu_pkg;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_EXU  = 2'd1;
   localparam logic [1:0] GNT_LSU  = 2'd2;

   localparam int unsigned STARVE_MAX_DEF = 4;
   localparam int unsigned STARVE_CNT_W   = 4;

endpackage

// File: rtl/wbu_gpr_arb_pick.sv
// Combinational two-way grant picker for the GPR write port.
// LSU wins contention unless prefer_exu is set by the caller's starve/pointer state.
module wbu_gpr_arb_pick (
   input  logic exu_valid,
   input  logic lsu_valid,
   input  logic prefer_exu,
   output logic gnt_exu_c,
   output logic gnt_lsu_c
);

   always_comb begin
      gnt_exu_c = exu_valid & (~lsu_valid | prefer_exu);
      gnt_lsu_c = lsu_valid & ~(exu_valid & prefer_exu);
   end

endmodule

// File: rtl/wbu_gpr_arb.sv
// GPR write-port arbiter between EXU and LSU write-back with a registered write port.
// WBU_ARB_RR_EN selects round-robin; otherwise fixed LSU priority with EXU anti-starvation.
module wbu_gpr_arb
   import wbu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 5,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic                  i_exu_valid,
   output logic                  o_exu_ready,
   input  logic [ID_WIDTH-1:0]   i_exu_wr_id,
   input  logic [DATA_WIDTH-1:0] i_exu_wr_data,
   input  logic                  i_lsu_valid,
   output logic                  o_lsu_ready,
   input  logic [ID_WIDTH-1:0]   i_lsu_wr_id,
   input  logic [DATA_WIDTH-1:0] i_lsu_wr_data,
   output logic                  o_wbu_gpr_wr_en,
   output logic [ID_WIDTH-1:0]   o_wbu_gpr_wr_id,
   output logic [DATA_WIDTH-1:0] o_wbu_gpr_wr_data,
   output logic [1:0]            o_arb_gnt_src
);

   logic prefer_exu;
   logic gnt_exu_c;
   logic gnt_lsu_c;

`ifdef WBU_ARB_RR_EN
   // Pointer names the side that wins the next contention; it always points away from the last winner.
   logic rr_ptr_exu;

   assign prefer_exu = rr_ptr_exu;

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         rr_ptr_exu <= 1'b0;
      end else if (gnt_lsu_c) begin
         rr_ptr_exu <= 1'b1;
      end else if (gnt_exu_c) begin
         rr_ptr_exu <= 1'b0;
      end
   end
`else
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   // Consecutive cycles a valid EXU request has been denied.
   logic [STARVE_CNT_W-1:0] starve_cnt;

   assign prefer_exu = (starve_cnt == STARVE_LIM);

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         starve_cnt <= '0;
      end else if (!i_exu_valid || gnt_exu_c) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
      end
   end
`endif

   wbu_gpr_arb_pick u_pick (
      .exu_valid  (i_exu_valid),
      .lsu_valid  (i_lsu_valid),
      .prefer_exu (prefer_exu),
      .gnt_exu_c  (gnt_exu_c),
      .gnt_lsu_c  (gnt_lsu_c)
   );

   assign o_exu_ready = gnt_exu_c & ~i_sys_rst;
   assign o_lsu_ready = gnt_lsu_c & ~i_sys_rst;

   // Write-port register; x0 targets are accepted and reported but never strobed.
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         o_wbu_gpr_wr_en   <= 1'b0;
         o_wbu_gpr_wr_id   <= '0;
         o_wbu_gpr_wr_data <= '0;
         o_arb_gnt_src     <= GNT_NONE;
      end else if (o_exu_ready) begin
         o_wbu_gpr_wr_en   <= (i_exu_wr_id != '0);
         o_wbu_gpr_wr_id   <= i_exu_wr_id;
         o_wbu_gpr_wr_data <= i_exu_wr_data;
         o_arb_gnt_src     <= GNT_EXU;
      end else if (o_lsu_ready) begin
         o_wbu_gpr_wr_en   <= (i_lsu_wr_id != '0);
         o_wbu_gpr_wr_id   <= i_lsu_wr_id;
         o_wbu_gpr_wr_data <= i_lsu_wr_data;
         o_arb_gnt_src     <= GNT_LSU;
      end else begin
         o_wbu_gpr_wr_en   <= 1'b0;
         o_arb_gnt_src     <= GNT_NONE;
      end
   end

endmodule

// File: tb/tb_wbu_gpr_arb.sv
// Self-checking bench for wbu_gpr_arb: directed plan steps followed by random traffic
// checked against a cycle-level reference model. Honours WBU_ARB_RR_EN.
module tb_wbu_gpr_arb;
   import wbu_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 5;
   localparam int unsigned SM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          exu_v, lsu_v;
   logic          exu_rdy, lsu_rdy;
   logic [IW-1:0] exu_id, lsu_id;
   logic [DW-1:0] exu_data, lsu_data;
   logic          wr_en;
   logic [IW-1:0] wr_id;
   logic [DW-1:0] wr_data;
   logic [1:0]    gnt_src;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int            m_cnt;
   bit            m_ptr_exu;
   logic          m_en;
   logic [IW-1:0] m_id;
   logic [DW-1:0] m_data;
   logic [1:0]    m_src;
   bit            g_exu, g_lsu;

   always #5 clk = ~clk;

   wbu_gpr_arb #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .STARVE_MAX(SM)) dut (
      .i_sys_clk         (clk),
      .i_sys_rst         (rst),
      .i_exu_valid       (exu_v),
      .o_exu_ready       (exu_rdy),
      .i_exu_wr_id       (exu_id),
      .i_exu_wr_data     (exu_data),
      .i_lsu_valid       (lsu_v),
      .o_lsu_ready       (lsu_rdy),
      .i_lsu_wr_id       (lsu_id),
      .i_lsu_wr_data     (lsu_data),
      .o_wbu_gpr_wr_en   (wr_en),
      .o_wbu_gpr_wr_id   (wr_id),
      .o_wbu_gpr_wr_data (wr_data),
      .o_arb_gnt_src     (gnt_src)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Who should win this cycle, from the arbitration rules alone.
   task automatic model_grant();
      g_exu = 1'b0;
      g_lsu = 1'b0;
      if (!rst) begin
         if (exu_v && lsu_v) begin
`ifdef WBU_ARB_RR_EN
            if (m_ptr_exu) g_exu = 1'b1; else g_lsu = 1'b1;
`else
            if (m_cnt >= int'(SM)) g_exu = 1'b1; else g_lsu = 1'b1;
`endif
         end else begin
            g_exu = exu_v;
            g_lsu = lsu_v;
         end
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_en = 1'b0; m_id = '0; m_data = '0; m_src = 2'd0;
         m_cnt = 0; m_ptr_exu = 1'b0;
         return;
      end
      if (g_exu) begin
         m_en = (exu_id != 0); m_id = exu_id; m_data = exu_data; m_src = 2'd1;
      end else if (g_lsu) begin
         m_en = (lsu_id != 0); m_id = lsu_id; m_data = lsu_data; m_src = 2'd2;
      end else begin
         m_en = 1'b0; m_src = 2'd0;
      end
      if (exu_v && !g_exu) m_cnt = (m_cnt + 1 > int'(SM)) ? int'(SM) : m_cnt + 1;
      else                 m_cnt = 0;
      if (g_lsu)      m_ptr_exu = 1'b1;
      else if (g_exu) m_ptr_exu = 1'b0;
   endtask

   // One clock: inputs already driven after the falling edge.
   task automatic cycle();
      #1;
      model_grant();
      chk("exu_ready", 64'(exu_rdy), 64'(g_exu));
      chk("lsu_ready", 64'(lsu_rdy), 64'(g_lsu));
      @(posedge clk);
      model_update();
      #1;
      chk("wr_en",   64'(wr_en),   64'(m_en));
      chk("wr_id",   64'(wr_id),   64'(m_id));
      chk("wr_data", 64'(wr_data), 64'(m_data));
      chk("gnt_src", 64'(gnt_src), 64'(m_src));
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] exp_seq [6];
      logic [1:0] tmp_src;

      rst = 1'b1; exu_v = 1'b0; lsu_v = 1'b0;
      exu_id = '0; exu_data = '0; lsu_id = '0; lsu_data = '0;
      m_cnt = 0; m_ptr_exu = 1'b0; m_en = 1'b0; m_id = '0; m_data = '0; m_src = 2'd0;
      @(negedge clk);
      cycle();
      chk("reset_wr_en", 64'(wr_en), 64'd0);
      chk("reset_src",   64'(gnt_src), 64'd0);
      chk("reset_data",  64'(wr_data), 64'd0);

      // EXU-only request
      rst = 1'b0;
      exu_v = 1'b1; exu_id = 5'd1; exu_data = 32'h1;
      cycle();
      chk("exu_only_src",  64'(gnt_src), 64'(GNT_EXU));
      chk("exu_only_en",   64'(wr_en),   64'd1);
      chk("exu_only_data", 64'(wr_data), 64'h1);
      exu_v = 1'b0;

      // Idle: outputs quiet, id/data hold the last write
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("idle_src", 64'(gnt_src), 64'd0);
         chk("idle_id",  64'(wr_id),   64'd1);
      end

      // x0 write from LSU is accepted but not strobed
      lsu_v = 1'b1; lsu_id = 5'd0; lsu_data = 32'hFFFF_FFFF;
      cycle();
      chk("x0_en",  64'(wr_en),   64'd0);
      chk("x0_src", 64'(gnt_src), 64'(GNT_LSU));
      lsu_v = 1'b0;

      // Contention from a clean reset
      rst = 1'b1;
      cycle();
      rst = 1'b0;
`ifdef WBU_ARB_RR_EN
      exp_seq = '{GNT_LSU, GNT_EXU, GNT_LSU, GNT_EXU, GNT_LSU, GNT_EXU};
`else
      exp_seq = '{GNT_LSU, GNT_LSU, GNT_LSU, GNT_LSU, GNT_EXU, GNT_LSU};
`endif
      exu_v = 1'b1; exu_id = 5'd3; exu_data = 32'h3;
      lsu_v = 1'b1; lsu_id = 5'd2; lsu_data = 32'h2;
      for (int i = 0; i < 6; i++) begin
         cycle();
         tmp_src = exp_seq[i];
         chk($sformatf("contend_src%0d", i), 64'(gnt_src), 64'(tmp_src));
         chk($sformatf("contend_id%0d", i), 64'(wr_id), (tmp_src == GNT_EXU) ? 64'd3 : 64'd2);
      end
      exu_v = 1'b0;

      // Reset mid-stream with LSU still requesting
      lsu_id = 5'd4; lsu_data = 32'h44;
      rst = 1'b1;
      #1;
      chk("rst_lsu_ready", 64'(lsu_rdy), 64'd0);
      cycle();
      chk("rst_mid_en",  64'(wr_en),   64'd0);
      chk("rst_mid_src", 64'(gnt_src), 64'd0);
      rst = 1'b0;
      cycle();
      chk("post_rst_src", 64'(gnt_src), 64'(GNT_LSU));
      chk("post_rst_id",  64'(wr_id),   64'd4);
      lsu_v = 1'b0;
      cycle();

      // Random traffic: requesters hold until accepted, small ids for collisions and x0
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         cycle();
         if (g_exu || !exu_v) begin
            exu_v    = ($urandom_range(0, 3) != 0);
            exu_id   = IW'($urandom_range(0, 3));
            exu_data = $urandom;
         end
         if (g_lsu || !lsu_v) begin
            lsu_v    = ($urandom_range(0, 2) != 0);
            lsu_id   = IW'($urandom_range(0, 3));
            lsu_data = $urandom;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wbu_gpr_arb.md
Name: wbu_gpr_arb

Overview:
- Arbitrates the single GPR write port between two write-back requesters: the EXU (ALU/PC results) and the LSU (load returns, which arrive late).
- Sits between the EXU/LSU result paths and the register file, alongside wbu.
- Grants at most one requester per cycle and registers the winner onto the GPR write port.
- Uses fixed LSU priority with an EXU anti-starvation counter.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ID_WIDTH, 5, width of GPR index.
- STARVE_MAX, 4, consecutive denied cycles after which EXU is force-granted (range 1..15).

Ports:
- i_sys_clk  input  1  clock; all state updates on rising edge.
- i_sys_rst  input  1  synchronous, active-high reset.
- i_exu_valid  input  1  EXU holds a write-back request.
- o_exu_ready  output  1  EXU request accepted this cycle.
- i_exu_wr_id  input  ID_WIDTH  EXU destination GPR.
- i_exu_wr_data  input  DATA_WIDTH  EXU write data.
- i_lsu_valid  input  1  LSU holds a load-return request.
- o_lsu_ready  output  1  LSU request accepted this cycle.
- i_lsu_wr_id  input  ID_WIDTH  LSU destination GPR.
- i_lsu_wr_data  input  DATA_WIDTH  LSU write data.
- o_wbu_gpr_wr_en  output  1  GPR write strobe.
- o_wbu_gpr_wr_id  output  ID_WIDTH  GPR write index.
- o_wbu_gpr_wr_data  output  DATA_WIDTH  GPR write data.
- o_arb_gnt_src  output  2  registered source of current write: 0 none, 1 EXU, 2 LSU.

Behaviour:
- Reset (i_sys_rst=1 at edge): all outputs 0; starvation counter 0; RR pointer selects LSU.
  - o_exu_ready and o_lsu_ready are forced 0 while i_sys_rst=1.
- Handshake:
  - Transfer occurs when valid&ready.
  - Requester must hold valid, id and data stable until ready.
  - ready is combinational from the valids and the counter, and never depends on ready.
- Grant rule (fixed-priority mode):
  - Only LSU valid -> LSU.
  - Only EXU valid -> EXU.
  - Both valid -> LSU, unless starve_cnt == STARVE_MAX, then EXU.
  - Neither valid -> no grant.
- Starvation counter, width 4:
  - Increments (saturating at STARVE_MAX) each cycle EXU is valid and not granted.
  - Clears when EXU is granted or i_exu_valid=0.
- Latency: 1 cycle. A transfer at edge N drives the write-port outputs during cycle N+1.
  - No transfer -> o_wbu_gpr_wr_en=0; id/data hold previous values; o_arb_gnt_src=0.
- x0 suppression:
  - A transfer with id 0 is accepted (ready=1).
  - o_arb_gnt_src reports the source, but o_wbu_gpr_wr_en=0.
- Throughput: one write per cycle; back-to-back grants allowed; no internal buffering beyond the output register.
- Same id from both requesters simultaneously: winner writes first, loser writes a later cycle; the later write is final.
- Reset mid-operation:
  - An in-flight registered write is dropped (wr_en=0 the cycle after reset).
  - Requesters still asserting valid are re-arbitrated from the first cycle after reset deasserts.

Optional Feature:
- Macro WBU_ARB_RR_EN.
- Defined:
  - Round-robin arbitration with a 1-bit pointer.
  - On contention, the pointer's side wins; the pointer flips to the other side after any grant.
  - Single-requester cycles grant the requester and set the pointer to the other side.
  - Starvation counter not instantiated.
- Undefined: fixed LSU priority with the starvation counter as above.

Decomposition:
- Shared package (wbu_pkg):
  - Grant-source encodings GNT_NONE=2'd0, GNT_EXU=2'd1, GNT_LSU=2'd2.
  - Default STARVE_MAX.
- One sub-module: wbu_gpr_arb_pick. Purely combinational: inputs are the valids plus starve/pointer state; outputs are one-hot grants.
- The top holds the counter/pointer and output register.

Test Plan:
- EXU-only request: EXU valid, id=1, data=32'h1 -> o_exu_ready=1 same cycle; next cycle wr_en=1, id=1, data=32'h1, gnt_src=1.
- Contention: both valid continuously, LSU id=2 data=32'h2, EXU id=3 data=32'h3, STARVE_MAX=4 -> four LSU grants, fifth cycle EXU granted, counter clears, then LSU again.
- x0 write: LSU id=0 data=32'hFFFF_FFFF -> lsu_ready=1; next cycle wr_en=0, gnt_src=2.
- Reset mid-stream: assert i_sys_rst for 1 cycle while LSU valid -> readies 0 during reset; all outputs 0 next cycle; LSU granted the cycle after reset deasserts.
- WBU_ARB_RR_EN defined, both valid continuously -> grants alternate LSU, EXU, LSU, EXU; ids alternate 2,3,2,3.
- Idle: no valids for 5 cycles -> wr_en=0, gnt_src=0 throughout, id/data unchanged.
